// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_device_tx
// Function : PS/2 device-side transmitter. Queued bytes go out as 11-bit
//            frames (start, 8 data LSB-first, odd parity, stop).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       inject_parity_err,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       tx_done
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_DIV_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int c_DW      = $clog2(c_DIV_MAX);
    localparam logic [c_DW-1:0] c_HP_LAST  = c_DW'(HALF_PERIOD - 1);
    localparam logic [c_DW-1:0] c_GAP_LAST = c_DW'(GAP_CYCLES - 1);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_in_ready;

    state_t          r_state;
    logic [c_DW-1:0] r_div;
    logic [3:0]      r_bit_idx;
    logic [9:0]      r_frame;
    logic            r_ps2_clk;
    logic            r_ps2_data;
    logic            r_busy;
    logic            r_tx_done;

    logic            w_push;
    logic            w_pop;
    logic            w_gap_end;
    logic [c_AW:0]   w_count_next;
    logic [7:0]      w_head;
    logic            w_parity;

    // in_ready is registered, so a full FIFO refuses a byte even while popping
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_gap_end = (r_state == S_GAP) && (r_div == c_GAP_LAST);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_parity  = (~^w_head) ^ inject_parity_err;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != c_FULL);
        end
    end

    // r_frame holds the bits still to be sent after the one on the line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_frame    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_busy    <= ((r_state != S_IDLE) && !w_gap_end) || w_pop || (w_count_next != '0);
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame    <= {1'b1, w_parity, w_head};
                        r_bit_idx  <= '0;
                        r_div      <= '0;
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b0;
                        r_state    <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (r_div == c_HP_LAST) begin
                        r_div     <= '0;
                        r_ps2_clk <= 1'b0;
                        r_state   <= S_LOW;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_div == c_HP_LAST) begin
                        r_div     <= '0;
                        r_ps2_clk <= 1'b1;
                        if (r_bit_idx != 4'd10) begin
                            r_bit_idx  <= r_bit_idx + 4'd1;
                            r_ps2_data <= r_frame[0];
                            r_frame    <= {1'b1, r_frame[9:1]};
                            r_state    <= S_HIGH;
                        end else begin
                            r_ps2_data <= 1'b1;
                            r_tx_done  <= 1'b1;
                            r_state    <= S_GAP;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_device_tx
// Function : Directed self-checking bench for ps2_device_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_device_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       inject_parity_err = 1'b0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       tx_done;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    ps2_device_tx #(
        .HALF_PERIOD(8),
        .GAP_CYCLES (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .inject_parity_err(inject_parity_err),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .busy             (busy),
        .tx_done          (tx_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic inj);
        logic acc;
        acc = 1'b0;
        in_data           = b;
        inject_parity_err = inj;
        in_valid          = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Decode one frame off the lines: data sampled at each falling ps2_clk.
    task automatic capture(output logic [10:0] f, output int t_load, output int t_done);
        logic found;
        logic prev;
        int   nb;
        f = '0; t_load = 0; t_done = 0; found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (ps2_clk && !ps2_data) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check("start_timeout", 0, 1);
            return;
        end
        t_load = cyc;
        prev   = 1'b1;
        nb     = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (prev && !ps2_clk) begin
                f[nb] = ps2_data;
                nb++;
            end
            prev = ps2_clk;
            if (nb == 11) break;
        end
        if (nb != 11) begin
            check("bits_timeout", nb, 11);
            return;
        end
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (tx_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("done_timeout", 0, 1);
        t_done = cyc;
    endtask

    logic [7:0] stream [6] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'h12, 8'h34};

    initial begin
        logic [10:0] f;
        int          tl, td;
        logic [10:0] sf [6];
        int          st [6];
        int          n_done, n_low, nfall;
        logic        prev;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_clk", ps2_clk, 1);
        check("rst_data", ps2_data, 1);
        check("rst_done", tx_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 and 176-cycle frame
        push(8'h1C, 1'b0);
        capture(f, tl, td);
        check("frame_1c", f, 11'h438);
        check("frame_len", td - tl, 176);
        @(negedge clock);
        check("done_pulse_width", tx_done, 0);
        repeat (14) @(negedge clock);
        check("gap_busy", busy, 1);
        check("gap_lines", {ps2_clk, ps2_data}, 2'b11);
        @(negedge clock);
        check("busy_drop", busy, 0);

        // parity boundaries
        push(8'h00, 1'b0);
        capture(f, tl, td);
        check("frame_00", f, 11'h600);
        push(8'hFF, 1'b0);
        capture(f, tl, td);
        check("frame_ff", f, 11'h7FE);
        push(8'h01, 1'b0);
        capture(f, tl, td);
        check("frame_01", f, 11'h402);

        // parity injection latched at load only, then a clean byte
        wait_idle();
        push(8'h1C, 1'b1);
        @(posedge clock);
        #1;
        inject_parity_err = 1'b0;
        capture(f, tl, td);
        check("frame_1c_bad_par", f, 11'h638);
        push(8'h32, 1'b0);
        capture(f, tl, td);
        check("frame_32", f, 11'h464);

        // back-to-back stream with FIFO filling up
        wait_idle();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(stream[i], 1'b0);
                    if (i == 4) check("in_ready_full", in_ready, 0);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    capture(sf[i], st[i], td);
                end
            end
        join
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stream_%0d", i), sf[i], {1'b1, ~^stream[i], stream[i], 1'b0});
            if (i > 0) check($sformatf("spacing_%0d", i), st[i] - st[i-1], 193);
        end

        // reset in the middle of the frame at bit_idx 4
        wait_idle();
        push(8'h00, 1'b0);
        prev  = 1'b1;
        nfall = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (prev && !ps2_clk) nfall++;
            prev = ps2_clk;
            if (nfall == 5) break;
        end
        check("mid_falls", nfall, 5);
        #3;
        check("mid_lines", {ps2_clk, ps2_data}, 2'b00);
        reset = 1'b1;
        #1;
        check("async_lines", {ps2_clk, ps2_data}, 2'b11);
        check("async_busy", busy, 0);
        check("async_ready", in_ready, 1);
        @(negedge clock);
        reset  = 1'b0;
        n_done = 0;
        n_low  = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (tx_done) n_done++;
            if (!ps2_clk || !ps2_data) n_low++;
        end
        check("post_rst_done", n_done, 0);
        check("post_rst_lines", n_low, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
